// File: rtl/shift_normalizer.sv
// shift_normalizer: normalizes a word by shifting it left one bit per clock
// until its MSB is set. It returns the normalized word and the shift count
// that produced it. Valid/ready handshake on both sides.
// Optional build macro SHIFT_NORMALIZER_SIGNED_EN adds an in_signed port for
// two's-complement normalization. With in_signed=1 the shift stops when the
// top two bits differ.
module shift_normalizer #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef SHIFT_NORMALIZER_SIGNED_EN
    input  logic             in_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shift,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic [SW-1:0]    r_cnt;
    logic [SW-1:0]    w_cnt_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             w_in_norm;
    logic             w_in_degen;
    logic             w_sh_norm;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
    logic             r_signed;
    logic             w_signed_nxt;
`endif

    assign w_shifted = r_work << 1;

    // Termination and degenerate-input tests for the incoming and shifted words
    always_comb begin
`ifdef SHIFT_NORMALIZER_SIGNED_EN
        w_in_norm  = in_signed ? (in_data[WIDTH-1] ^ in_data[WIDTH-2]) : in_data[WIDTH-1];
        w_in_degen = in_signed ? ((in_data == '0) || (in_data == '1)) : (in_data == '0);
        w_sh_norm  = r_signed ? (w_shifted[WIDTH-1] ^ w_shifted[WIDTH-2]) : w_shifted[WIDTH-1];
`else
        w_in_norm  = in_data[WIDTH-1];
        w_in_degen = (in_data == '0);
        w_sh_norm  = w_shifted[WIDTH-1];
`endif
    end

    // Next-state and datapath updates; hold everything by default
    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_cnt_nxt    = r_cnt;
        w_zero_nxt   = r_zero;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
        w_signed_nxt = r_signed;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_work_nxt  = in_data;
                    w_cnt_nxt   = '0;
                    w_zero_nxt  = w_in_degen;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
                    w_signed_nxt = in_signed;
`endif
                    w_state_nxt = (w_in_degen || w_in_norm) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_shifted;
                w_cnt_nxt  = r_cnt + SW'(1);
                if (w_sh_norm) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Working register, counter, flags and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work      <= '0;
            r_cnt       <= '0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
            r_signed    <= 1'b0;
`endif
        end else begin
            r_work      <= w_work_nxt;
            r_cnt       <= w_cnt_nxt;
            r_zero      <= w_zero_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
`ifdef SHIFT_NORMALIZER_SIGNED_EN
            r_signed    <= w_signed_nxt;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_work;
    assign out_shift = r_cnt;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: the driver pushes model results
// on accept, and the monitor compares them when results are presented.
// Define SHIFT_NORMALIZER_SIGNED_EN to exercise the signed mode as well.
module tb_shift_normalizer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [SW-1:0]    out_shift;
    logic             out_zero;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
    logic             in_signed = 1'b0;
`endif

    shift_normalizer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SHIFT_NORMALIZER_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    sh;
        logic             z;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;   // 0 random, 1 held low, 2 held high
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
        else               out_ready = (rdy_mode == 2);
    end

    // Reference: leading-zero count from floor(log2) arithmetic
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic s);
        exp_t             e;
        int               lz;
        logic [WIDTH-1:0] y;
        e.data = x;
        e.sh   = '0;
        e.z    = 1'b0;
        e.acc  = 0;
        if (!s) begin
            if (x == '0) e.z = 1'b1;
            else begin
                lz     = WIDTH - $clog2(int'(x) + 1);
                e.sh   = SW'(lz);
                e.data = x << lz;
            end
        end else begin
            if (x == '0 || x == '1) e.z = 1'b1;
            else begin
                y      = x[WIDTH-1] ? ~x : x;
                lz     = WIDTH - $clog2(int'(y) + 1) - 1;
                e.sh   = SW'(lz);
                e.data = x << lz;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one word and record the expected result when it is accepted
    task automatic send(input logic [WIDTH-1:0] x, input logic s);
        exp_t e;
        int   n;
        bit   ok;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = x;
`ifdef SHIFT_NORMALIZER_SIGNED_EN
        in_signed = s;
`endif
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            e     = model(x, s);
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    // Monitor: compares presented results and latency against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            check("in_ready_low_in_done", 32'(in_ready), 32'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%0h required=none", out_data);
            end else begin
                e = q[0];
                if (!prev_valid) check("latency", 32'(cyc - e.acc), 32'(e.sh) + 32'd1);
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_shift", 32'(out_shift), 32'(e.sh));
                check("out_zero", 32'(out_zero), 32'(e.z));
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic wait_valid(input logic lvl, input string name);
        int n;
        n = 0;
        while (out_valid !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== lvl) begin
            checks++;
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, out_valid, lvl);
        end
    endtask

    initial begin
        // Reset values
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_shift", 32'(out_shift), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        rst = 1'b0;

        // Directed corners with a ready consumer
        rdy_mode = 2;
        send(8'h01, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        send(8'h80, 1'b0);

        // Stalled consumer: result held, in_ready low, extra in_valid ignored
        rdy_mode = 1;
        send(8'h13, 1'b0);
        wait_valid(1'b1, "stall_valid_timeout");
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        rdy_mode = 2;
        @(negedge clk);
        wait_valid(1'b0, "stall_release_timeout");
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);

        // Reset in the third SHIFT cycle discards the word
        send(8'h02, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_shift", 32'(out_shift), 32'd0);
        check("midrst_out_zero", 32'(out_zero), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'h40, 1'b0);

        // Random unsigned traffic with random back-pressure
        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(WIDTH'($urandom), 1'b0);
        end

`ifdef SHIFT_NORMALIZER_SIGNED_EN
        // Signed normalization
        rdy_mode = 2;
        send(8'hF3, 1'b1);
        send(8'h0C, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
`endif

        // Drain the scoreboard
        rdy_mode = 2;
        begin
            int n;
            n = 0;
            while ((q.size() != 0 || out_valid) && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (q.size() != 0) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout actual=%0d required=0", q.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
